msu_data_prefetch: RTL and testbench
====================================

// Module: msu_data_prefetch
// PURPOSE
//  Data-track read engine downstream of the MSU register block. Converts MSU seek/advance
//  strobes (data_seek level, data_req pulse, data_addr) into byte reads on the
//  memory port. Streams results through a small prefetch FIFO so that $2001 reads always see the next byte.
//  Answers seeks with a data_ack pulse that clears the MSU data-busy status bit.
// PARAMETERS
//  DEPTH   8   prefetch FIFO entries (power of 2, >=2)
//  ADDR_W  32  byte address width of data track / memory port
// PORTS
//  CLK        in   1       system clock
//  RST        in   1       asynchronous, active-high reset
//  ENABLE     in   1       0: no new memory reads issued; FIFO/outputs hold
//  data_addr  in   ADDR_W  seek target from MSU, sampled on data_seek rising edge
//  data_seek  in   1       level; rising edge = new seek
//  data_req   in   1       1-cycle pulse: consumer took current byte, advance
//  data       out  8       current head byte
//  data_ack   out  1       1-cycle pulse: first byte after seek is valid on data
//  underrun   out  1       sticky: data_req seen with FIFO empty; cleared by seek
//  mem_addr   out  ADDR_W  read address
//  mem_rd     out  1       read request, held high until mem_ack
//  mem_ack    in   1       1-cycle: mem_dout valid, request complete
//  mem_dout   in   8       read data
// BEHAVIOUR
//  Reset: data=0, data_ack=0, underrun=0, mem_rd=0, mem_addr=0, FIFO empty, skip=0, state=IDLE.
//   mem_rd drops asynchronously with RST; an ack arriving after reset release while no
//   request is outstanding is ignored.
//  State machine:
//   IDLE->SEEK on data_seek rising edge.
//   SEEK: flush FIFO; fetch_addr<=data_addr; skip<=0; underrun<=0.
//    If a read is outstanding, set discard. Go to FILL.
//   FILL: issue reads. First byte pushed -> data_ack pulses next cycle, go to STREAM.
//   STREAM: keep FIFO topped up. A seek edge in any state re-enters SEEK.
//  Read issue: when ENABLE && !mem_rd && count+inflight<DEPTH && state in FILL/STREAM,
//   mem_rd<=1 and mem_addr<=fetch_addr. Only one read is outstanding at a time.
//  On mem_ack: mem_rd<=0 and fetch_addr+=1 (wraps mod 2^ADDR_W).
//   If discard is set: drop the byte, clear discard; fetch_addr is not advanced (reloaded by SEEK).
//   Else if skip>0: drop the byte, skip-=1.
//   Else: push the byte.
//  Latency: seek edge at cycle T -> mem_rd=1, mem_addr=data_addr at T+1 (if none outstanding).
//   mem_ack at cycle A -> data=byte and data_ack=1 at A+1.
//  data: registered FIFO head. Updates the cycle after a pop or after a push into an empty FIFO.
//   Holds its last value when the FIFO is empty.
//  data_req with count>0: pop.
//   With count==0: underrun<=1 and skip+=1, so later bytes stay address-aligned.
//   skip saturates at DEPTH.
//  Simultaneous push+pop: count unchanged. Pop reads the old head; the pushed byte goes to the tail.
//   If empty, the pushed byte is consumed as a skip (skip not incremented).
//  data_seek edge coincident with mem_ack: the seek wins; the acked byte is dropped.
//  data_seek edge coincident with data_req: the seek wins; the pop is ignored.
//  data_req in SEEK/FILL before data_ack: ignored, no underrun.
//  ENABLE low mid-read: the outstanding read completes normally; no further issue.
//  Full: no issue while count+inflight==DEPTH.
// TESTING
//  1. Seek 0x0000_1000, memory returns addr[7:0] with 2-cycle latency:
//     mem_addr 0x1000..0x1007 are issued, data_ack pulses once, data=0x00.
//     8 data_req pulses then give data 0x01..0x08.
//  2. Hold data_req low after the fill: exactly DEPTH reads are issued, then mem_rd stays 0.
//     A single data_req triggers exactly one new read at 0x1008.
//  3. Reseek to 0x2000 while a read of 0x1003 is outstanding: that byte is discarded.
//     The next mem_addr is 0x2000 and data_ack fires with data=0x00 (from 0x2000).
//  4. Memory stalled, two data_req pulses on an empty FIFO: underrun=1, skip=2.
//     The first two returned bytes are dropped and the next data is the byte from base+3.
//  5. Seek to 0xFFFF_FFFE: addresses FFFFFFFE, FFFFFFFF, 00000000 are issued in order.
//  6. Assert RST mid-read: mem_rd falls in the same cycle and all outputs hold reset values.
//     A late mem_ack after release pushes nothing.

Source files
------------

// File: rtl/msu_data_prefetch.sv
// msu_data_prefetch: MSU data-track read engine with a prefetch FIFO
//   clk, rst            clock, asynchronous active-high reset
//   enable              gates issue of new memory reads
//   data_addr/data_seek seek target and seek level (rising edge starts a seek)
//   data_req            consumer advance pulse
//   data/data_ack       current head byte, pulse when the first byte after a seek is valid
//   underrun            sticky: advance requested while the FIFO was empty
//   mem_*               single-outstanding byte read port
module msu_data_prefetch #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_seek,
    input  logic              data_req,
    output logic [7:0]        data,
    output logic              data_ack,
    output logic              underrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
    state_t state, state_nxt;
    logic seek_q, discard;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CW-1:0] count, skip, skip_dec, skip_nxt;
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [7:0] fifo [DEPTH];
    logic seek_edge, ack, take, push_raw, pop_req, pop, starve, push, under_set, issue;
    // The seek edge cycle itself performs the seek actions so the first read issues one cycle later.
    always_comb begin
        seek_edge = data_seek & ~seek_q;
        ack       = mem_ack & mem_rd;
        take      = ack & ~discard & ~seek_edge;
        push_raw  = take & (skip == '0);
        pop_req   = data_req & (state == STREAM) & ~seek_edge;
        pop       = pop_req & (count != '0);
        starve    = pop_req & (count == '0);
        // A byte arriving while the consumer advances an empty FIFO is consumed on the spot.
        push      = push_raw & ~starve;
        under_set = starve & ~push_raw;
        issue     = enable & ~mem_rd & (seek_edge | (state != IDLE && count < CW'(DEPTH)));
        rd_nxt    = rd_ptr + PW'(1);
        skip_dec  = skip - CW'(take & ~push_raw);
        skip_nxt  = seek_edge ? '0 : (under_set && skip_dec != CW'(DEPTH)) ? skip_dec + CW'(1) : skip_dec;
        state_nxt = seek_edge ? FILL : (state == FILL && push) ? STREAM : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seek_q     <= 1'b0;
            discard    <= 1'b0;
            fetch_addr <= '0;
            count      <= '0;
            skip       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            data       <= '0;
            data_ack   <= 1'b0;
            underrun   <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
        end else begin
            seek_q     <= data_seek;
            data_ack   <= push & (state == FILL);
            skip       <= skip_nxt;
            underrun   <= seek_edge ? 1'b0 : underrun | under_set;
            // A read still in flight at seek time belongs to the old stream.
            discard    <= seek_edge ? (mem_rd & ~mem_ack) : discard & ~ack;
            fetch_addr <= seek_edge ? data_addr : fetch_addr + ADDR_W'(take);
            mem_rd     <= issue | (mem_rd & ~ack);
            if (issue) mem_addr <= seek_edge ? data_addr : fetch_addr;
            count      <= seek_edge ? '0 : count + CW'(push) - CW'(pop);
            rd_ptr     <= seek_edge ? '0 : rd_ptr + PW'(pop);
            wr_ptr     <= seek_edge ? '0 : wr_ptr + PW'(push);
            if (pop) data <= count > CW'(1) ? fifo[rd_nxt] : push ? mem_dout : data;
            else if (push && count == '0) data <= mem_dout;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= mem_dout;
    end
endmodule

// File: tb/tb_msu_data_prefetch.sv
// tb_msu_data_prefetch: directed scoreboard bench for msu_data_prefetch
module tb_msu_data_prefetch;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b1;
    logic        data_seek = 1'b0, data_req = 1'b0, mem_ack = 1'b0;
    logic [31:0] data_addr = '0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  data;
    logic        data_ack, underrun, mem_rd;
    logic [31:0] mem_addr;
    int          tests = 0, fails = 0, ack_cnt = 0, a0 = 0;
    bit          stall = 1'b0, late_ack = 1'b0, busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_a = '0;
    logic        rd_prev = 1'b0;
    logic [31:0] exp_addr [$];

    msu_data_prefetch #(.DEPTH(8), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .data_addr(data_addr), .data_seek(data_seek),
        .data_req(data_req), .data(data), .data_ack(data_ack), .underrun(underrun),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue monitor (pops the address scoreboard) and memory model returning addr[7:0].
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (data_ack) ack_cnt++;
            if (mem_rd && !rd_prev) begin
                if (exp_addr.size() == 0) check("unexpected_issue", mem_rd, 1'b0);
                else check("mem_addr", mem_addr, exp_addr.pop_front());
            end
        end
        rd_prev = mem_rd;
        if (rst) begin
            busy = 1'b0;
            mem_ack = 1'b0;
        end else if (mem_ack) mem_ack = 1'b0;
        else if (late_ack) begin
            mem_ack = 1'b1;
            mem_dout = 8'h55;
            late_ack = 1'b0;
        end else if (busy) begin
            if (!stall) begin
                if (cnt <= 1) begin
                    mem_ack = 1'b1;
                    mem_dout = req_a[7:0];
                    busy = 1'b0;
                end else cnt--;
            end
        end else if (mem_rd) begin
            busy = 1'b1;
            cnt = 2;
            req_a = mem_addr;
        end
    end

    task automatic seek(input logic [31:0] a);
        data_addr = a;
        data_seek = 1'b1;
        @(negedge clk);
        data_seek = 1'b0;
    endtask

    task automatic req();
        data_req = 1'b1;
        @(negedge clk);
        data_req = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int i = 0;
        while (!data_ack && i < 80) begin
            @(negedge clk);
            i++;
        end
        check(tag, data_ack, 1'b1);
    endtask

    task automatic wait_data_change(input string tag, input logic [7:0] old, input logic [7:0] exp);
        int i = 0;
        while (data === old && i < 80) begin
            @(negedge clk);
            i++;
        end
        check(tag, data, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_ack", data_ack, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_read", mem_rd, 1'b0);

        for (int i = 0; i < 8; i++) exp_addr.push_back(32'h1000 + i);
        seek(32'h1000);
        wait_ack("t1_ack");
        check("t1_data0", data, 8'h00);
        repeat (50) @(negedge clk);
        check("t1_ack_once", ack_cnt, 1);
        check("t2_fill_issued", exp_addr.size(), 0);
        check("t2_full_no_read", mem_rd, 1'b0);
        exp_addr.push_back(32'h1008);
        req();
        check("t1_pop1", data, 8'h01);
        repeat (12) @(negedge clk);
        check("t2_one_refill", exp_addr.size(), 0);
        check("t2_full_again", mem_rd, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            exp_addr.push_back(32'h1007 + i);
            req();
            check("t1_pop", data, i);
            repeat (8) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("t1_refills_issued", exp_addr.size(), 0);

        a0 = ack_cnt;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h1000 + i);
        seek(32'h1000);
        begin
            int i = 0;
            while (!(mem_rd && mem_addr == 32'h1003) && i < 100) begin
                @(negedge clk);
                i++;
            end
            check("t3_reach_1003", mem_addr, 32'h1003);
        end
        for (int i = 0; i < 8; i++) exp_addr.push_back(32'h2000 + i);
        seek(32'h2000);
        wait_ack("t3_ack");
        check("t3_data", data, 8'h00);
        repeat (50) @(negedge clk);
        check("t3_issued", exp_addr.size(), 0);
        check("t3_ack_count", ack_cnt, a0 + 2);

        a0 = ack_cnt;
        exp_addr.push_back(32'h3000);
        exp_addr.push_back(32'h3001);
        seek(32'h3000);
        wait_ack("t4_ack");
        check("t4_data0", data, 8'h00);
        stall = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_stalled_rd", mem_rd, 1'b1);
        req();
        check("t4_pop_no_underrun", underrun, 1'b0);
        req();
        req();
        check("t4_underrun", underrun, 1'b1);
        check("t4_data_hold", data, 8'h00);
        for (int i = 2; i <= 10; i++) exp_addr.push_back(32'h3000 + i);
        stall = 1'b0;
        wait_data_change("t4_skip_align", 8'h00, 8'h03);
        check("t4_underrun_sticky", underrun, 1'b1);
        repeat (50) @(negedge clk);
        check("t4_issued", exp_addr.size(), 0);
        check("t4_ack_count", ack_cnt, a0 + 1);

        exp_addr.push_back(32'hFFFF_FFFE);
        exp_addr.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) exp_addr.push_back(i);
        seek(32'hFFFF_FFFE);
        check("t5_underrun_cleared", underrun, 1'b0);
        req();
        wait_ack("t5_ack");
        check("t5_data", data, 8'hFE);
        check("t5_fill_req_ignored", underrun, 1'b0);
        repeat (50) @(negedge clk);
        exp_addr.push_back(32'h6);
        req();
        check("t5_pop_ff", data, 8'hFF);
        exp_addr.push_back(32'h7);
        req();
        check("t5_pop_wrap", data, 8'h00);
        exp_addr.push_back(32'h8);
        req();
        check("t5_pop_01", data, 8'h01);
        repeat (20) @(negedge clk);
        check("t5_issued", exp_addr.size(), 0);

        stall = 1'b1;
        exp_addr.push_back(32'h5000);
        seek(32'h5000);
        check("t6_outstanding", mem_rd, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rd_async", mem_rd, 1'b0);
        check("t6_addr", mem_addr, 32'h0);
        check("t6_data", data, 8'h00);
        check("t6_ack", data_ack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        late_ack = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_late_ack_data", data, 8'h00);
        check("t6_late_ack_rd", mem_rd, 1'b0);
        for (int i = 0; i < 8; i++) exp_addr.push_back(32'h6010 + i);
        seek(32'h6010);
        wait_ack("t6_ack_after");
        check("t6_data_after", data, 8'h10);
        repeat (50) @(negedge clk);
        check("t6_issued", exp_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
